measurement_scheduler: RTL

MEASUREMENT_SCHEDULER -- requirements
Module: measurement_scheduler

---
 rtl/measurement_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/measurement_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : measurement_scheduler                                          |
// | Purpose : Round-robin sensor measurement sequencer with period/timeout.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module measurement_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int COUNTER_SIZE = 16,
  parameter int PERIOD_MS    = 1000,
  parameter int TIMEOUT_MS   = 50,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_CHANNELS-1:0]         channel_mask,
  input  logic                            done_in,
  input  logic                            error_in,
  output logic                            start,
  output logic [$clog2(NUM_CHANNELS)-1:0] channel,
  output logic                            busy,
  output logic                            result_valid,
  output logic                            result_error,
  output logic                            timeout
);

  localparam int C_CHAN_W = $clog2(NUM_CHANNELS);
  localparam int C_SUM_W  = C_CHAN_W + 1;

  localparam logic [COUNTER_SIZE-1:0] C_ONE       = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] C_CNT_MAX   = '1;
  localparam logic [COUNTER_SIZE-1:0] C_TICK_LAST = COUNTER_SIZE'(TICK_DIV - 1);
  localparam logic [COUNTER_SIZE-1:0] C_PERIOD    = COUNTER_SIZE'(PERIOD_MS);
  localparam logic [COUNTER_SIZE-1:0] C_TIMEOUT   = COUNTER_SIZE'(TIMEOUT_MS);
  localparam logic [C_CHAN_W-1:0]     C_LAST_INIT = C_CHAN_W'(NUM_CHANNELS - 1);
  localparam logic [C_SUM_W-1:0]      C_NUM_CH    = C_SUM_W'(NUM_CHANNELS);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_PERIOD = 3'd1,
    ST_SELECT      = 3'd2,
    ST_START       = 3'd3,
    ST_WAIT_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [COUNTER_SIZE-1:0] r_tick_cnt;
  logic [COUNTER_SIZE-1:0] r_ms_cnt;
  logic [COUNTER_SIZE-1:0] w_ms_inc;
  logic                    w_tick;
  logic                    w_timed;
  logic                    w_period_hit;
  logic                    w_timeout_hit;

  logic [C_CHAN_W-1:0] r_last_served;
  logic [C_CHAN_W-1:0] r_channel;
  logic [C_CHAN_W-1:0] w_sel_chan;
  logic [C_CHAN_W-1:0] w_idx;
  logic [C_SUM_W-1:0]  w_sum;
  logic                w_sel_found;

  logic w_accept;
  logic w_timeout_fire;
  logic w_select_take;

  logic r_start;
  logic r_busy;
  logic r_result_valid;
  logic r_result_error;
  logic r_timeout;

  // The ms count advances only on the tick wrap, so a "reached" condition
  // is detected on that wrap clock and the dwell is exactly N*TICK_DIV.
  assign w_tick        = (r_tick_cnt == C_TICK_LAST);
  assign w_ms_inc      = (r_ms_cnt == C_CNT_MAX) ? r_ms_cnt : r_ms_cnt + C_ONE;
  assign w_period_hit  = w_tick && (w_ms_inc >= C_PERIOD);
  assign w_timeout_hit = w_tick && (w_ms_inc >= C_TIMEOUT);
  assign w_timed       = (r_state == ST_WAIT_PERIOD) || (r_state == ST_WAIT_DONE);

  // Rotating-priority search starting just above the last served channel.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_chan  = r_last_served;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      w_sum = {1'b0, r_last_served} + C_SUM_W'(k);
      if (w_sum >= C_NUM_CH) begin
        w_sum = w_sum - C_NUM_CH;
      end
      w_idx = w_sum[C_CHAN_W-1:0];
      if (!w_sel_found && channel_mask[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel_chan  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:        if (enable) w_state_next = ST_SELECT;
      ST_SELECT:      w_state_next = w_sel_found ? ST_START : ST_WAIT_PERIOD;
      ST_START:       w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE:   if (done_in || w_timeout_hit) w_state_next = ST_WAIT_PERIOD;
      ST_WAIT_PERIOD: if (w_period_hit) w_state_next = ST_SELECT;
      default:        w_state_next = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && !enable) begin
      w_state_next = ST_IDLE;
    end
  end

  assign w_accept       = (r_state == ST_WAIT_DONE) && enable && done_in;
  assign w_timeout_fire = (r_state == ST_WAIT_DONE) && enable && !done_in && w_timeout_hit;
  assign w_select_take  = (r_state == ST_SELECT) && enable && w_sel_found;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counters restart on any state change so each timed state begins at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_ms_cnt   <= '0;
    end else if ((w_state_next != r_state) || !w_timed) begin
      r_tick_cnt <= '0;
      r_ms_cnt   <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + C_ONE;
      if (w_tick) begin
        r_ms_cnt <= w_ms_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_served  <= C_LAST_INIT;
      r_channel      <= '0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_error <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_start        <= (w_state_next == ST_START);
      r_busy         <= (w_state_next == ST_START) || (w_state_next == ST_WAIT_DONE);
      r_result_valid <= w_accept;
      r_timeout      <= w_timeout_fire;
      if (w_accept) begin
        r_result_error <= error_in;
      end
      if (w_select_take) begin
        r_channel     <= w_sel_chan;
        r_last_served <= w_sel_chan;
      end
    end
  end

  assign start        = r_start;
  assign channel      = r_channel;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_error = r_result_error;
  assign timeout      = r_timeout;

endmodule
`default_nettype wire
